// File: rtl/tank_pkg.sv
// Shared types and defaults for the tank hit/damage controller.
// Holds the state encoding, the play-mode constant and the default
// tuning values used by every file of this block.
package tank_pkg;

    // Damage / life-cycle states of one tank.
    typedef enum logic [2:0] {
        ST_ALIVE     = 3'd0,
        ST_HIT       = 3'd1,
        ST_INVULN    = 3'd2,
        ST_DEAD      = 3'd3,
        ST_RESPAWN   = 3'd4,
        ST_GAME_OVER = 3'd5
    } hit_state_t;

    // Only this mode value lets the game advance; everything else is paused.
    localparam logic [1:0] MODE_PLAY = 2'b10;

    // Default tuning values.
    localparam logic [9:0] DEF_HIT_HALF      = 10'd19;
    localparam logic [2:0] DEF_INIT_HP       = 3'd3;
    localparam logic [1:0] DEF_INIT_LIVES    = 2'd2;
    localparam logic [7:0] DEF_INVULN_FRAMES = 8'd60;
    localparam logic [7:0] DEF_DEAD_FRAMES   = 8'd120;

    // Frame counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] satInc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end
        return value + 8'd1;
    endfunction

endpackage

// File: rtl/tank_hit_ctrl_frame_tick_gen.sv
// Frame tick generator: turns the vertical-sync frame clock (already
// synchronous to Clk) into a single-Clk pulse per rising edge.
// A delayed copy of frame_clk is compared with the live value and the
// result is registered, giving one cycle of latency and a clean pulse.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic frameClkDly_q;
    logic frameTick_q;

    // Delayed copy of the frame clock and registered rising-edge strobe.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frameClkDly_q <= 1'b0;
            frameTick_q   <= 1'b0;
        end else begin
            frameClkDly_q <= frame_clk;
            frameTick_q   <= frame_clk & ~frameClkDly_q;
        end
    end

    assign frame_tick = frameTick_q;

endmodule

// File: rtl/tank_hit_ctrl.sv
// Tank hit controller: detects an opposing bullet inside the tank hit box,
// feeds a registered stop back to the bullet block, and runs the
// hp / lives / invulnerability / death / respawn life cycle of the tank.
module tank_hit_ctrl
    import tank_pkg::*;
#(
    parameter logic [9:0] HIT_HALF      = DEF_HIT_HALF,
    parameter logic [2:0] INIT_HP       = DEF_INIT_HP,
    parameter logic [1:0] INIT_LIVES    = DEF_INIT_LIVES,
    parameter logic [7:0] INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter logic [7:0] DEAD_FRAMES   = DEF_DEAD_FRAMES
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [1:0] mode,
    input  logic       draw_bullet,
    input  logic [9:0] Bullet_X_Pos,
    input  logic [9:0] Bullet_Y_Pos,
    input  logic [9:0] Tank_X_Pos,
    input  logic [9:0] Tank_Y_Pos,
    output logic       stop_bullet,
    output logic [2:0] hp,
    output logic [1:0] lives,
    output logic       tank_alive,
    output logic       tank_flash,
    output logic       hit_pulse,
    output logic       game_over
);

    hit_state_t state_q, state_d;
    logic [2:0] hp_q, hp_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] frameCnt_q, frameCnt_d;
    logic       stopBullet_q;
    logic       stopPrev_q;

    logic        frameTick;
    logic        play;
    logic        tickEn;
    logic [10:0] bulletXHi, bulletYHi, tankXHi, tankYHi;
    logic        overlapX, overlapY, overlap;
    logic        hitCond;
    logic        stopRise;

    frame_tick_gen u_frame_tick_gen (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .frame_tick(frameTick)
    );

    assign play   = (mode == MODE_PLAY);
    assign tickEn = frameTick & play;

    // Hit box test with 11-bit sums on both sides, so no subtraction can
    // wrap around near the screen edges.
    assign bulletXHi = {1'b0, Bullet_X_Pos} + {1'b0, HIT_HALF};
    assign bulletYHi = {1'b0, Bullet_Y_Pos} + {1'b0, HIT_HALF};
    assign tankXHi   = {1'b0, Tank_X_Pos} + {1'b0, HIT_HALF};
    assign tankYHi   = {1'b0, Tank_Y_Pos} + {1'b0, HIT_HALF};

    assign overlapX = (bulletXHi >= {1'b0, Tank_X_Pos}) && ({1'b0, Bullet_X_Pos} <= tankXHi);
    assign overlapY = (bulletYHi >= {1'b0, Tank_Y_Pos}) && ({1'b0, Bullet_Y_Pos} <= tankYHi);
    assign overlap  = overlapX & overlapY;

    // A dead or finished tank cannot absorb bullets.
    assign hitCond = overlap & draw_bullet & play
                   & (state_q != ST_DEAD) & (state_q != ST_GAME_OVER);

    // Only a fresh contact counts as damage, so a lingering bullet hits once.
    assign stopRise = stopBullet_q & ~stopPrev_q;

    // Registered collision feedback and its delayed copy for edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stopBullet_q <= 1'b0;
            stopPrev_q   <= 1'b0;
        end else begin
            stopBullet_q <= hitCond;
            stopPrev_q   <= stopBullet_q;
        end
    end

    // Life-cycle state, hit points, lives and frame counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_ALIVE;
            hp_q       <= INIT_HP;
            lives_q    <= INIT_LIVES;
            frameCnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            lives_q    <= lives_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    // Next-state logic; a paused game freezes everything, including HIT.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        lives_d = lives_q;

        if (play) begin
            case (state_q)
                ST_ALIVE: begin
                    if (stopRise) begin
                        state_d = ST_HIT;
                    end
                end
                ST_HIT: begin
                    hp_d = (hp_q == 3'd0) ? 3'd0 : hp_q - 3'd1;
                    if (hp_d == 3'd0) begin
                        state_d = (lives_q == 2'd0) ? ST_GAME_OVER : ST_DEAD;
                    end else begin
                        state_d = ST_INVULN;
                    end
                end
                ST_INVULN: begin
                    if (tickEn && (frameCnt_q == INVULN_FRAMES - 8'd1)) begin
                        state_d = ST_ALIVE;
                    end
                end
                ST_DEAD: begin
                    if (tickEn && (frameCnt_q == DEAD_FRAMES - 8'd1)) begin
                        state_d = ST_RESPAWN;
                    end
                end
                ST_RESPAWN: begin
                    hp_d    = INIT_HP;
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    state_d = ST_INVULN;
                end
                ST_GAME_OVER: begin
                    state_d = ST_GAME_OVER;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end
    end

    // Frame counter: cleared on any state change, counts ticks in the timed states.
    always_comb begin
        frameCnt_d = frameCnt_q;
        if (state_d != state_q) begin
            frameCnt_d = 8'd0;
        end else if (tickEn && ((state_q == ST_INVULN) || (state_q == ST_DEAD))) begin
            frameCnt_d = satInc8(frameCnt_q);
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        tank_alive = 1'b0;
        tank_flash = 1'b0;
        case (state_q)
            ST_ALIVE: begin
                tank_alive = 1'b1;
                tank_flash = 1'b1;
            end
            ST_HIT: begin
                tank_alive = 1'b1;
                tank_flash = 1'b1;
            end
            ST_INVULN: begin
                tank_alive = 1'b1;
                tank_flash = frameCnt_q[3];
            end
            default: begin
                tank_alive = 1'b0;
                tank_flash = 1'b0;
            end
        endcase
    end

    assign stop_bullet = stopBullet_q;
    assign hp          = hp_q;
    assign lives       = lives_q;
    assign hit_pulse   = (state_q == ST_HIT) & play;
    assign game_over   = (state_q == ST_GAME_OVER);

endmodule
